// File: rtl/icache_pkg.sv
// icache_pkg: shared widths and FSM state encoding for the instruction cache
package icache_pkg;
    localparam int LINE_W     = 64;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = 26;
    localparam int CPU_ADDR_W = 27;
    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, FILL, DELIVER, TMO} state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: CPU fetch port, invalidate request and RAM-controller instruction port
interface icache_if;
    import icache_pkg::*;
    logic                  cpu_stb;
    logic [CPU_ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0]     cpu_dout;
    logic                  cpu_ack;
    logic                  cpu_timeout;
    logic                  inv;
    logic                  mem_stb;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_din;
    logic                  mem_ack;
    logic                  mem_timeout;
    modport slave (
        input  cpu_stb, cpu_addr, inv, mem_din, mem_ack, mem_timeout,
        output cpu_dout, cpu_ack, cpu_timeout, mem_stb, mem_addr
    );
    modport master (
        output cpu_stb, cpu_addr, inv, mem_din, mem_ack, mem_timeout,
        input  cpu_dout, cpu_ack, cpu_timeout, mem_stb, mem_addr
    );
endinterface

// File: rtl/icache_mem.sv
// icache_mem: valid/tag/data arrays with synchronous read, one write port and a valid-clear port
module icache_mem import icache_pkg::*; #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 18
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic                  clr,
    input  logic [INDEX_BITS-1:0] clr_idx
);
    logic [2**INDEX_BITS-1:0] valid;
    logic [TAG_BITS-1:0]      tags [2**INDEX_BITS];
    logic [LINE_W-1:0]        data [2**INDEX_BITS];
    always_ff @(posedge clk) begin
        if (clr)
            valid[clr_idx] <= 1'b0;
        else if (we)
            valid[wr_idx] <= 1'b1;
        rd_valid <= valid[rd_idx];
    end
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
        rd_tag  <= tags[rd_idx];
        rd_data <= data[rd_idx];
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, one 64-bit line per RAM-controller word
module icache import icache_pkg::*; #(
    parameter int INDEX_BITS = 8,
    localparam int TAG_BITS  = 26 - INDEX_BITS
) (
    input logic     clk,
    input logic     rst,
    icache_if.slave bus
);
    state_t                state, state_n;
    logic [INDEX_BITS-1:0] cnt;
    logic                  pend;
    logic [LINE_W-1:0]     fill_buf, rd_data, line;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_valid, hit;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    assign idx = bus.cpu_addr[INDEX_BITS:1];
    assign tag = bus.cpu_addr[CPU_ADDR_W-1:INDEX_BITS+1];
    icache_mem #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_mem (
        .clk     (clk),
        .rd_idx  (idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (state == FILL && bus.mem_ack && !rst),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (bus.mem_din),
        .clr     (state == INIT),
        .clr_idx (cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= state == INIT ? cnt + INDEX_BITS'(1) : '0;
            // an invalidate arriving mid-transaction is held until the next IDLE cycle
            pend  <= state == IDLE ? 1'b0 : pend | (bus.inv && state != INIT);
        end
        if (state == FILL && bus.mem_ack)
            fill_buf <= bus.mem_din;
    end
    always_comb begin
        state_n = state;
        case (state)
            INIT:    state_n = &cnt ? IDLE : INIT;
            IDLE:    state_n = (bus.inv || pend) ? INIT : bus.cpu_stb ? LOOKUP : IDLE;
            LOOKUP:  state_n = hit ? IDLE : FILL;
            FILL:    state_n = bus.mem_ack ? DELIVER : bus.mem_timeout ? TMO : FILL;
            DELIVER: state_n = IDLE;
            TMO:     state_n = IDLE;
            default: state_n = INIT;
        endcase
    end
    assign hit             = rd_valid && rd_tag == tag;
    assign line            = state == DELIVER ? fill_buf : rd_data;
    assign bus.cpu_dout    = bus.cpu_addr[0] ? line[WORD_W-1:0] : line[LINE_W-1:WORD_W];
    assign bus.cpu_ack     = (state == LOOKUP && hit) || state == DELIVER;
    assign bus.cpu_timeout = state == TMO;
    assign bus.mem_stb     = state == FILL;
    assign bus.mem_addr    = bus.cpu_addr[CPU_ADDR_W-1:1];
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache with a cycle-exact RAM-controller responder
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   r_cyc, r_nstb;
    logic [31:0] r_dout;
    logic [25:0] r_maddr;
    logic        r_ack, r_to;

    icache_if bus ();
    icache dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds cpu_stb until ack/timeout; answers the lat-th mem_stb cycle with ack (or timeout).
    task automatic fetch(input logic [26:0] a, input int lat, input logic [63:0] din,
                         input bit tmo, input int inv_at);
        @(negedge clk);
        bus.cpu_stb  = 1'b1;
        bus.cpu_addr = a;
        r_cyc = 0; r_nstb = 0; r_ack = 1'b0; r_to = 1'b0; r_dout = 'x; r_maddr = 'x;
        for (int i = 0; i < 1000; i++) begin
            r_cyc++;
            if (bus.inv) bus.inv = 1'b0;
            if (r_cyc == inv_at) bus.inv = 1'b1;
            if (bus.mem_stb) begin
                r_nstb++;
                r_maddr = bus.mem_addr;
            end
            if (bus.cpu_ack || bus.cpu_timeout) begin
                r_ack  = bus.cpu_ack;
                r_to   = bus.cpu_timeout;
                r_dout = bus.cpu_dout;
                break;
            end
            if (bus.mem_stb && r_nstb >= lat) begin
                bus.mem_din = din;
                if (tmo) bus.mem_timeout = 1'b1;
                else     bus.mem_ack = 1'b1;
            end
            @(negedge clk);
            bus.mem_ack     = 1'b0;
            bus.mem_timeout = 1'b0;
        end
        bus.inv     = 1'b0;
        bus.cpu_stb = 1'b0;
        chk("done_in_budget", 64'(r_ack | r_to), 64'd1);
    endtask

    initial begin
        bus.cpu_stb = 1'b0; bus.cpu_addr = '0; bus.inv = 1'b0;
        bus.mem_din = '0; bus.mem_ack = 1'b0; bus.mem_timeout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(bus.cpu_ack), 64'd0);
        chk("rst_tmo", 64'(bus.cpu_timeout), 64'd0);
        chk("rst_mstb", 64'(bus.mem_stb), 64'd0);
        rst = 1'b0;
        bus.cpu_stb = 1'b1;
        bus.cpu_addr = 27'h0000010;

        // request during the sweep is serviced after 256 INIT cycles, then cold miss
        fetch(27'h0000010, 5, 64'h11111111_22222222, 1'b0, 0);
        chk("sweep_cyc", 64'(r_cyc), 64'd263);
        chk("cold_ack", 64'(r_ack), 64'd1);
        chk("cold_dout", 64'(r_dout), 64'h11111111);
        chk("cold_maddr", 64'(r_maddr), 64'h0000008);
        chk("cold_nstb", 64'(r_nstb), 64'd5);

        fetch(27'h0000011, 1, 64'h0, 1'b0, 0);
        chk("hit_cyc", 64'(r_cyc), 64'd2);
        chk("hit_dout", 64'(r_dout), 64'h22222222);
        chk("hit_nstb", 64'(r_nstb), 64'd0);
        fetch(27'h0000010, 1, 64'h0, 1'b0, 0);
        chk("hit0_dout", 64'(r_dout), 64'h11111111);
        chk("hit0_cyc", 64'(r_cyc), 64'd2);

        // conflict: same index 0x08, tag 1
        fetch(27'h0000210, 2, 64'h33333333_44444444, 1'b0, 0);
        chk("conf_cyc", 64'(r_cyc), 64'd5);
        chk("conf_dout", 64'(r_dout), 64'h33333333);
        chk("conf_maddr", 64'(r_maddr), 64'h0000108);
        chk("conf_nstb", 64'(r_nstb), 64'd2);
        fetch(27'h0000211, 1, 64'h0, 1'b0, 0);
        chk("conf_hit", 64'(r_dout), 64'h44444444);
        chk("conf_hit_nstb", 64'(r_nstb), 64'd0);
        fetch(27'h0000010, 1, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 0);
        chk("evict_nstb", 64'(r_nstb), 64'd1);
        chk("evict_cyc", 64'(r_cyc), 64'd4);
        chk("evict_dout", 64'(r_dout), 64'hAAAAAAAA);

        // timeout leaves the resident line at index 0 untouched
        fetch(27'h0000000, 1, 64'h77777777_88888888, 1'b0, 0);
        chk("idx0_dout", 64'(r_dout), 64'h77777777);
        fetch(27'h4000000, 3, 64'hDEADBEEF_DEADBEEF, 1'b1, 0);
        chk("tmo_to", 64'(r_to), 64'd1);
        chk("tmo_ack", 64'(r_ack), 64'd0);
        chk("tmo_cyc", 64'(r_cyc), 64'd6);
        chk("tmo_maddr", 64'(r_maddr), 64'h2000000);
        fetch(27'h0000001, 1, 64'h0, 1'b0, 0);
        chk("tmo_keep_nstb", 64'(r_nstb), 64'd0);
        chk("tmo_keep_dout", 64'(r_dout), 64'h88888888);
        fetch(27'h4000000, 1, 64'h0, 1'b1, 0);
        chk("retry_nstb", 64'(r_nstb), 64'd1);
        chk("retry_to", 64'(r_to), 64'd1);

        // invalidate during FILL: fill completes, then sweep clears everything
        fetch(27'h0000040, 3, 64'h99999999_00000001, 1'b0, 4);
        chk("inv_fill_cyc", 64'(r_cyc), 64'd6);
        chk("inv_fill_dout", 64'(r_dout), 64'h99999999);
        fetch(27'h0000041, 1, 64'h12345678_9ABCDEF0, 1'b0, 0);
        chk("inv_miss_nstb", 64'(r_nstb), 64'd1);
        chk("inv_miss_dout", 64'(r_dout), 64'h9ABCDEF0);
        fetch(27'h0000010, 2, 64'hCAFEF00D_0BADF00D, 1'b0, 0);
        chk("inv_miss2_nstb", 64'(r_nstb), 64'd2);
        chk("inv_miss2_dout", 64'(r_dout), 64'hCAFEF00D);

        // reset mid-FILL drops mem_stb on the next cycle
        @(negedge clk);
        bus.cpu_stb = 1'b1;
        bus.cpu_addr = 27'h0000080;
        repeat (2) @(negedge clk);
        chk("rfill_mstb", 64'(bus.mem_stb), 64'd1);
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_din = 64'hFFFFFFFF_FFFFFFFF;
        @(negedge clk);
        chk("rfill_mstb_off", 64'(bus.mem_stb), 64'd0);
        chk("rfill_ack", 64'(bus.cpu_ack), 64'd0);
        bus.mem_ack = 1'b0;
        bus.cpu_stb = 1'b0;
        rst = 1'b0;
        fetch(27'h0000080, 2, 64'h0F0F0F0F_F0F0F0F0, 1'b0, 0);
        chk("rfill_miss_nstb", 64'(r_nstb), 64'd2);
        chk("rfill_miss_dout", 64'(r_dout), 64'h0F0F0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
